// File: rtl/text_grid_draw.sv
// Character-grid renderer: walks a COLS x ROWS text plane, fetches each glyph
// row from ROM and streams one pixel write per glyph bit over a valid/ready port.
module text_grid_draw #(
  parameter int COLS    = 32,
  parameter int ROWS    = 16,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 8,
  parameter int CXW     = 5,
  parameter int CYW     = 4,
  parameter int XW      = 8,
  parameter int YW      = 8,
  parameter int GAW     = 11
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               MODE,
  input  logic [23:0]        FG_RGB,
  input  logic [23:0]        BG_RGB,
  output logic               BUSY,
  output logic               DONE,
  output logic [CXW-1:0]     CX,
  output logic [CYW-1:0]     CY,
  input  logic [7:0]         CHAR,
  output logic [GAW-1:0]     GLYPH_ADDR,
  input  logic [GLYPH_W-1:0] GLYPH_ROW,
  output logic               PX_VALID,
  input  logic               PX_READY,
  output logic [XW-1:0]      X,
  output logic [YW-1:0]      Y,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic [2:0]         fsm_state
);

  localparam int GYW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int CLW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  localparam logic [GYW-1:0] GY_LAST = GYW'(GLYPH_H - 1);
  localparam logic [CLW-1:0] CL_LAST = CLW'(GLYPH_W - 1);
  localparam logic [CXW-1:0] CX_LAST = CXW'(COLS - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHAR_RD  = 3'd1,
    S_CHAR_LAT = 3'd2,
    S_ROW_RD   = 3'd3,
    S_ROW_LAT  = 3'd4,
    S_EMIT     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic                mode_q;
  logic [23:0]         fg_q;
  logic [23:0]         bg_q;
  logic [7:0]          char_q;
  logic [GYW-1:0]      gy;
  logic [CLW-1:0]      col;
  logic [GLYPH_W-1:0]  shreg;

  logic                adv;
  logic                last_col;
  logic                last_gy;
  logic                last_cell;
  logic                load_px;
  logic                pix_bit;
  logic [CLW-1:0]      pix_col;
  logic [GLYPH_W-1:0]  sh_next;

  assign fsm_state = state_q;

  // Handshake: a pixel transfers on a rising edge where PX_VALID and PX_READY
  // are both high; while PX_VALID is high and PX_READY low the pixel registers
  // and the walker hold. An empty EMIT step (PX_VALID low) always advances.
  assign adv       = ~PX_VALID | PX_READY;
  assign last_col  = (col == CL_LAST);
  assign last_gy   = (gy == GY_LAST);
  assign last_cell = (CX == CX_LAST) && (CY == CY_LAST);
  assign sh_next   = shreg << 1;

  function automatic logic [GAW-1:0] gaddr(input logic [7:0] c, input logic [GYW-1:0] r);
    return GAW'(c) * GAW'(GLYPH_H) + GAW'(r);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (START) state_d = S_CHAR_RD;
      S_CHAR_RD:  state_d = S_CHAR_LAT;
      S_CHAR_LAT: state_d = S_ROW_RD;
      S_ROW_RD:   state_d = S_ROW_LAT;
      S_ROW_LAT:  state_d = S_EMIT;
      S_EMIT: begin
        if (adv && last_col) begin
          if (!last_gy)       state_d = S_ROW_RD;
          else if (last_cell) state_d = S_DONE;
          else                state_d = S_CHAR_RD;
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pixel registers are loaded on the edge that enters each EMIT step, so the
  // first bit comes straight from GLYPH_ROW and later bits from the shifter.
  always_comb begin
    load_px = (state_q == S_ROW_LAT) || ((state_q == S_EMIT) && adv && !last_col);
    pix_bit = sh_next[GLYPH_W-1];
    pix_col = col + CLW'(1);
    if (state_q == S_ROW_LAT) begin
      pix_bit = GLYPH_ROW[GLYPH_W-1];
      pix_col = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q     <= 1'b0;
      fg_q       <= '0;
      bg_q       <= '0;
      char_q     <= '0;
      gy         <= '0;
      col        <= '0;
      shreg      <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CX         <= '0;
      CY         <= '0;
      GLYPH_ADDR <= '0;
      PX_VALID   <= 1'b0;
      X          <= '0;
      Y          <= '0;
      R          <= '0;
      G          <= '0;
      B          <= '0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            mode_q <= MODE;
            fg_q   <= FG_RGB;
            bg_q   <= BG_RGB;
            CX     <= '0;
            CY     <= '0;
            BUSY   <= 1'b1;
          end
        end
        S_CHAR_LAT: begin
          char_q     <= CHAR;
          gy         <= '0;
          GLYPH_ADDR <= gaddr(CHAR, '0);
        end
        S_ROW_LAT: begin
          shreg <= GLYPH_ROW;
          col   <= '0;
        end
        S_EMIT: begin
          if (adv) begin
            if (!last_col) begin
              col   <= col + CLW'(1);
              shreg <= sh_next;
            end else if (!last_gy) begin
              gy         <= gy + GYW'(1);
              GLYPH_ADDR <= gaddr(char_q, gy + GYW'(1));
            end else if (!last_cell) begin
              if (CX == CX_LAST) begin
                CX <= '0;
                CY <= CY + CYW'(1);
              end else begin
                CX <= CX + CXW'(1);
              end
            end else begin
              BUSY <= 1'b0;
              DONE <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (load_px) begin
        X        <= XW'(CX) * XW'(GLYPH_W) + XW'(pix_col);
        Y        <= YW'(CY) * YW'(GLYPH_H) + YW'(gy);
        PX_VALID <= pix_bit | ~mode_q;
        if (pix_bit)      {R, G, B} <= fg_q;
        else if (!mode_q) {R, G, B} <= bg_q;
      end else if ((state_q == S_EMIT) && adv) begin
        PX_VALID <= 1'b0;
      end
    end
  end

endmodule
